// File: rtl/deser_aggregate.sv
// Protobuf wire-format walker: fetches bytes over the 8-lane DRAM port and emits (field_id, wire_type, value) records.
// Define DESER_ERR_CODE_EN to add the err_code output that classifies the failure.
module deser_aggregate #(
  parameter int MAX_VARINT_BYTES = 10,
  parameter int WAIT_LIMIT       = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [63:0]      src,
  input  logic [14:0]      size,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic             field_valid,
  input  logic             field_ready,
  output logic [28:0]      field_id,
  output logic [2:0]       wire_type,
  output logic [63:0]      field_value,
  output logic [63:0]      field_offset,
  output logic [7:0]       dram_en,
  output logic             dram_rdwr,
  output logic [7:0][63:0] dram_addr,
  input  logic [7:0][7:0]  dram_data_in,
  input  logic [7:0]       dram_valid
`ifdef DESER_ERR_CODE_EN
  ,
  output logic [2:0]       err_code
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_TAG, S_VALUE, S_LEN, S_EMIT, S_SKIP
  } state_t;

  localparam logic [2:0]  ERR_TRUNC   = 3'd1;
  localparam logic [2:0]  ERR_WT      = 3'd2;
  localparam logic [2:0]  ERR_LONG    = 3'd3;
  localparam logic [2:0]  ERR_OVR     = 3'd4;
  localparam logic [2:0]  ERR_TIMEOUT = 3'd5;
  localparam logic [7:0]  VMAX        = 8'(MAX_VARINT_BYTES - 1);
  localparam logic [15:0] WMAX        = 16'(WAIT_LIMIT - 1);

  state_t          state_q, state_d, ret_q, ret_d;
  logic [63:0]     cursor_q, cursor_d;
  logic [14:0]     rem_q, rem_d;
  logic [7:0][7:0] buf_q, buf_d;
  logic [3:0]      cnt_q, cnt_d, idx_q, idx_d;
  logic [7:0]      req_q, req_d, got_q, got_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [63:0]     acc_q, acc_d;
  logic [6:0]      shift_q, shift_d;
  logic [7:0]      vcnt_q, vcnt_d;
  logic [28:0]     id_q, id_d;
  logic [2:0]      wt_q, wt_d;
  logic [63:0]     val_q, val_d, off_q, off_d;
  logic            fvalid_q, fvalid_d, err_q, err_d, done_q, done_d;
`ifdef DESER_ERR_CODE_EN
  logic [2:0]      code_q, code_d;
  assign err_code = code_q;
`endif

  logic [7:0]  fetch_mask;
  logic [3:0]  fetch_n;
  logic [7:0]  byte_v;
  logic        have_byte, vlast, vover, flast;
  logic [63:0] vacc, facc;
  logic [2:0]  fail;

  // A fetch never reads past the end of the message, so the buffer only holds message bytes.
  always_comb begin
    for (int i = 0; i < 8; i++) fetch_mask[i] = (rem_q > 15'(i));
    fetch_n = (rem_q >= 15'd8) ? 4'd8 : {1'b0, rem_q[2:0]};
  end

  always_comb begin
    dram_en   = '0;
    dram_addr = '0;
    if (state_q == S_FETCH) begin
      for (int i = 0; i < 8; i++) begin
        if (fetch_mask[i]) begin
          dram_en[i]   = 1'b1;
          dram_addr[i] = cursor_q + 64'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;  ret_d = ret_q;   cursor_d = cursor_q; rem_d = rem_q;
    buf_d = buf_q;      cnt_d = cnt_q;   idx_d = idx_q;       req_d = req_q;
    got_d = got_q;      wcnt_d = wcnt_q; acc_d = acc_q;       shift_d = shift_q;
    vcnt_d = vcnt_q;    id_d = id_q;     wt_d = wt_q;         val_d = val_q;
    off_d = off_q;      fvalid_d = fvalid_q; err_d = err_q;   done_d = 1'b0;
`ifdef DESER_ERR_CODE_EN
    code_d = code_q;
`endif
    fail      = 3'd0;
    byte_v    = buf_q[idx_q[2:0]];
    have_byte = (idx_q != cnt_q);
    vacc      = acc_q | (64'(byte_v[6:0]) << shift_q);
    facc      = acc_q | (64'(byte_v) << {vcnt_q[2:0], 3'b000});
    vlast     = ~byte_v[7];
    vover     = byte_v[7] && (vcnt_q >= VMAX);
    flast     = (wt_q == 3'd1) ? (vcnt_q == 8'd7) : (vcnt_q == 8'd3);

    case (state_q)
      S_IDLE: begin
        if (en) begin
          cursor_d = src;   rem_d = size;  err_d = 1'b0;
          cnt_d = '0;       idx_d = '0;    acc_d = '0;
          shift_d = '0;     vcnt_d = '0;   ret_d = S_TAG;
`ifdef DESER_ERR_CODE_EN
          code_d = 3'd0;
`endif
          if (size == '0) done_d = 1'b1;
          else            state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        req_d   = fetch_mask;
        got_d   = '0;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        for (int i = 0; i < 8; i++)
          if (req_q[i] && dram_valid[i] && !got_q[i]) buf_d[i] = dram_data_in[i];
        got_d = got_q | (req_q & dram_valid);
        if (got_d == req_q) begin
          cnt_d   = fetch_n;
          idx_d   = '0;
          state_d = ret_q;
        end else if (wcnt_q >= WMAX) fail = ERR_TIMEOUT;
        else wcnt_d = wcnt_q + 16'd1;
      end
      S_TAG, S_VALUE, S_LEN: begin
        if (rem_q == '0) begin
          // Running out exactly between fields is the normal end of message.
          if (state_q == S_TAG && vcnt_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else fail = ERR_TRUNC;
        end else if (!have_byte) begin
          ret_d   = state_q;
          state_d = S_FETCH;
        end else begin
          idx_d    = idx_q + 4'd1;
          cursor_d = cursor_q + 64'd1;
          rem_d    = rem_q - 15'd1;
          vcnt_d   = vcnt_q + 8'd1;
          shift_d  = shift_q + 7'd7;
          acc_d    = vacc;
          if (state_q == S_VALUE && wt_q != 3'd0) begin
            acc_d = facc;
            if (flast) begin
              val_d = facc;  off_d = '0;  fvalid_d = 1'b1;  state_d = S_EMIT;
              acc_d = '0;    shift_d = '0; vcnt_d = '0;
            end
          end else if (vover) fail = ERR_LONG;
          else if (vlast) begin
            acc_d = '0; shift_d = '0; vcnt_d = '0;
            if (state_q == S_TAG) begin
              id_d = vacc[31:3];
              wt_d = vacc[2:0];
              if (vacc == '0) fail = ERR_WT;
              else begin
                case (vacc[2:0])
                  3'd0, 3'd1, 3'd5: state_d = S_VALUE;
                  3'd2:             state_d = S_LEN;
                  default:          fail = ERR_WT;
                endcase
              end
            end else if (state_q == S_VALUE) begin
              val_d = vacc;  off_d = '0;  fvalid_d = 1'b1;  state_d = S_EMIT;
            end else if (vacc > {49'd0, rem_d}) fail = ERR_OVR;
            else begin
              val_d = vacc;  off_d = cursor_d;  fvalid_d = 1'b1;  state_d = S_EMIT;
            end
          end
        end
      end
      S_EMIT: begin
        if (field_ready) begin
          fvalid_d = 1'b0;
          if (wt_q == 3'd2) state_d = S_SKIP;
          else if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else state_d = S_TAG;
        end
      end
      S_SKIP: begin
        // Payload is only reported, so jump over it and refetch after it.
        cursor_d = cursor_q + val_q;
        rem_d    = rem_q - val_q[14:0];
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = S_TAG;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail != 3'd0) begin
      err_d    = 1'b1;
      done_d   = 1'b1;
      fvalid_d = 1'b0;
      state_d  = S_IDLE;
`ifdef DESER_ERR_CODE_EN
      code_d = fail;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE; ret_q <= S_TAG;  cursor_q <= '0; rem_q <= '0;
      buf_q <= '0;       cnt_q <= '0;     idx_q <= '0;    req_q <= '0;
      got_q <= '0;       wcnt_q <= '0;    acc_q <= '0;    shift_q <= '0;
      vcnt_q <= '0;      id_q <= '0;      wt_q <= '0;     val_q <= '0;
      off_q <= '0;       fvalid_q <= 1'b0; err_q <= 1'b0; done_q <= 1'b0;
`ifdef DESER_ERR_CODE_EN
      code_q <= '0;
`endif
    end else begin
      state_q <= state_d; ret_q <= ret_d;   cursor_q <= cursor_d; rem_q <= rem_d;
      buf_q <= buf_d;     cnt_q <= cnt_d;   idx_q <= idx_d;       req_q <= req_d;
      got_q <= got_d;     wcnt_q <= wcnt_d; acc_q <= acc_d;       shift_q <= shift_d;
      vcnt_q <= vcnt_d;   id_q <= id_d;     wt_q <= wt_d;         val_q <= val_d;
      off_q <= off_d;     fvalid_q <= fvalid_d; err_q <= err_d;   done_q <= done_d;
`ifdef DESER_ERR_CODE_EN
      code_q <= code_d;
`endif
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign field_valid  = fvalid_q;
  assign field_id     = id_q;
  assign wire_type    = wt_q;
  assign field_value  = val_q;
  assign field_offset = off_q;
  assign dram_rdwr    = 1'b0;

endmodule
